scoreboard_issue_ctrl: RTL and testbench

- Issue-stage hazard controller for the LC-3b pipeline.
- Keeps a per-register pending-write counter for all 8 architectural registers.
- Decides each cycle whether the decoded instruction may issue, using RAW/WAW rules.
- Updates the counters on issue (increment) and on writeback (decrement), and drives a flush/drain sequence that discards in-flight writebacks after a pipeline flush.

---
 rtl/lc3b_types.sv | 14 +
 rtl/scoreboard_issue_ctrl_pending_counter.sv | 36 +++
 rtl/scoreboard_issue_ctrl.sv | 106 ++++++++++
 tb/tb_scoreboard_issue_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, scoreboard FSM state, register count.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    DRAIN
  } sb_state_t;

  localparam int NUM_REGS = 8;

endpackage

// File: rtl/scoreboard_issue_ctrl_pending_counter.sv
// One per-register pending-write counter: up on issue, down on writeback,
// synchronous clear, plus zero/one/saturation and underflow flags.
module pending_counter #(
  parameter int CNT_W       = 2,
  parameter int MAX_PENDING = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic one,
  output logic sat,
  output logic underflow
);

  logic [CNT_W-1:0] cnt;

  assign zero      = (cnt == '0);
  assign one       = (cnt == CNT_W'(1));
  assign sat       = (cnt == CNT_W'(MAX_PENDING));
  assign underflow = dec & zero;

  // Simultaneous inc and dec cancel; a dec at zero holds the count at zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/scoreboard_issue_ctrl.sv
// LC-3b issue-stage scoreboard: RAW/WAW hazard check, pending-write counters,
// flush/drain FSM and stall counter. Define SCOREBOARD_WB_BYPASS_EN for wb forwarding.
module scoreboard_issue_ctrl
  import lc3b_types::*;
#(
  parameter int MAX_PENDING  = 3,
  parameter int CNT_W        = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec_valid,
  input  lc3b_reg                src1,
  input  lc3b_reg                src2,
  input  logic                   src1_used,
  input  logic                   src2_used,
  input  lc3b_reg                dest,
  input  logic                   dest_used,
  input  logic                   wb_valid,
  input  lc3b_reg                wb_reg,
  input  logic                   flush,
  output logic                   issue_ready,
  output logic                   issue_fire,
  output logic [NUM_REGS-1:0]    ready_vec,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   underflow_err
);

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  sb_state_t            state;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [NUM_REGS-1:0]  zero_v, one_v, sat_v, uf_v, inc_v, dec_v;
  logic                 active, wb_apply;
  logic                 src1_ok, src2_ok, hazard;

  assign active   = (state != DRAIN);
  assign wb_apply = wb_valid & active & !flush & !reset;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    assign inc_v[g] = issue_fire & dest_used & (dest == lc3b_reg'(g));
    assign dec_v[g] = wb_apply & (wb_reg == lc3b_reg'(g));

    pending_counter #(
      .CNT_W      (CNT_W),
      .MAX_PENDING(MAX_PENDING)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (flush),
      .inc      (inc_v[g]),
      .dec      (dec_v[g]),
      .zero     (zero_v[g]),
      .one      (one_v[g]),
      .sat      (sat_v[g]),
      .underflow(uf_v[g])
    );
  end

  assign ready_vec = zero_v;

  // A source with a single pending write retiring this cycle is forwarded when bypass exists.
  always_comb begin
    src1_ok     = zero_v[src1] | (WB_BYPASS & one_v[src1] & wb_valid & (wb_reg == src1));
    src2_ok     = zero_v[src2] | (WB_BYPASS & one_v[src2] & wb_valid & (wb_reg == src2));
    hazard      = (src1_used & !src1_ok) | (src2_used & !src2_ok) | (dest_used & sat_v[dest]);
    issue_ready = !hazard & !flush & active & !reset;
    issue_fire  = issue_ready & dec_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      drain_cnt     <= '0;
      stall_count   <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (flush) begin
        state     <= DRAIN;
        drain_cnt <= '0;
      end else begin
        case (state)
          RUN:     if (dec_valid && !issue_ready) state <= STALL;
          STALL:   if (issue_fire) state <= RUN;
          DRAIN: begin
            if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state <= RUN;
            else drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
          default: state <= RUN;
        endcase
      end
      if (dec_valid && !issue_ready && (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_W'(1);
      if (|uf_v)
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Directed scoreboard bench for scoreboard_issue_ctrl; expectations for
// issue_ready/issue_fire/ready_vec are queued per step and checked at negedge.
module tb_scoreboard_issue_ctrl;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset, dec_valid, src1_used, src2_used, dest_used, wb_valid, flush;
  lc3b_reg     src1, src2, dest, wb_reg;
  logic        issue_ready, issue_fire, underflow_err;
  logic [7:0]  ready_vec;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       rdy;
    logic       fire;
    logic [7:0] vec;
  } exp_t;
  exp_t q[$];

  int mcnt[8];
  int drain_left = 0;

  scoreboard_issue_ctrl #(
    .MAX_PENDING (3),
    .CNT_W       (2),
    .DRAIN_CYCLES(4),
    .STALL_CNT_W (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .src1         (src1),
    .src2         (src2),
    .src1_used    (src1_used),
    .src2_used    (src2_used),
    .dest         (dest),
    .dest_used    (dest_used),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .flush        (flush),
    .issue_ready  (issue_ready),
    .issue_fire   (issue_fire),
    .ready_vec    (ready_vec),
    .stall_count  (stall_count),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (obs=timeout exp=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mvec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (mcnt[i] == 0);
    return v;
  endfunction

  task automatic drv(input logic dv, input lc3b_reg s1, input logic s1u,
                     input lc3b_reg s2, input logic s2u, input lc3b_reg d, input logic du,
                     input logic wbv, input lc3b_reg wbr, input logic fl);
    dec_valid = dv; src1 = s1; src1_used = s1u; src2 = s2; src2_used = s2u;
    dest = d; dest_used = du; wb_valid = wbv; wb_reg = wbr; flush = fl;
  endtask

  task automatic idle();
    drv(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  // One clock step: queue expectations, compare at negedge, advance the count model.
  task automatic cyc(input string tag, input logic er, input logic ef);
    exp_t e;
    e.tag = tag; e.rdy = er; e.fire = ef; e.vec = mvec();
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk({e.tag, "/issue_ready"}, 32'(issue_ready), 32'(e.rdy));
    chk({e.tag, "/issue_fire"},  32'(issue_fire),  32'(e.fire));
    chk({e.tag, "/ready_vec"},   32'(ready_vec),   32'(e.vec));
    if (reset) begin
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
      drain_left = 0;
    end else if (flush) begin
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
      drain_left = 4;
    end else begin
      if (ef && dest_used) mcnt[dest] = mcnt[dest] + 1;
      if (wb_valid && drain_left == 0 && mcnt[wb_reg] > 0) mcnt[wb_reg] = mcnt[wb_reg] - 1;
      if (drain_left > 0) drain_left = drain_left - 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_cycle/issue_ready", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // idle after reset
    cyc("idle", 1'b1, 1'b0);
    chk("idle/stall_count", 32'(stall_count), 32'd0);
    chk("idle/underflow", 32'(underflow_err), 32'd0);

    // RAW on R3
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0); cyc("raw_issue_r3", 1'b1, 1'b1);
    drv(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); cyc("raw_stall", 1'b0, 1'b0);
    drv(1'b0, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0); cyc("raw_wb_r3", 1'b1, 1'b0);
    drv(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); cyc("raw_release", 1'b1, 1'b1);
    chk("raw/stall_count", 32'(stall_count), 32'd1);

    // WAW saturation on R5
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0); cyc("waw_fill", 1'b1, 1'b1);
    end
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0); cyc("waw_sat_stall", 1'b0, 1'b0);
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 3'd5, 1'b0); cyc("waw_wb_same_cycle", 1'b0, 1'b0);
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0); cyc("waw_fourth_issues", 1'b1, 1'b1);
    chk("waw/stall_count", 32'(stall_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0); cyc("waw_retire", 1'b1, 1'b0);
    end

    // same-reg issue+writeback, then underflow on R6
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0); cyc("sim_issue_r2", 1'b1, 1'b1);
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd2, 1'b0); cyc("sim_issue_wb_r2", 1'b1, 1'b1);
    drv(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0); cyc("sim_wb_r2", 1'b1, 1'b0);
    chk("sim/no_underflow", 32'(underflow_err), 32'd0);
    drv(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0); cyc("uf_wb_r6", 1'b1, 1'b0);
    chk("uf/set", 32'(underflow_err), 32'd1);
    idle(); cyc("uf_idle", 1'b1, 1'b0);
    chk("uf/sticky", 32'(underflow_err), 32'd1);

    // reset mid-STALL (src2 hazard)
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0); cyc("rst_issue_r3", 1'b1, 1'b1);
    drv(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); cyc("rst_src2_stall", 1'b0, 1'b0);
    reset = 1'b1; cyc("rst_cycle", 1'b0, 1'b0);
    reset = 1'b0;
    chk("rst/stall_count", 32'(stall_count), 32'd0);
    chk("rst/underflow", 32'(underflow_err), 32'd0);
    idle(); cyc("rst_idle", 1'b1, 1'b0);

    // flush with R1=2, R4=1
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0); cyc("fl_issue_r1a", 1'b1, 1'b1);
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0); cyc("fl_issue_r1b", 1'b1, 1'b1);
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0); cyc("fl_issue_r4", 1'b1, 1'b1);
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b1); cyc("fl_pulse", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 1'b0); cyc("fl_drain", 1'b0, 1'b0);
    end
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); cyc("fl_back_to_run", 1'b1, 1'b1);
    chk("fl/stall_count", 32'(stall_count), 32'd5);
    chk("fl/drain_wb_no_underflow", 32'(underflow_err), 32'd0);

    // second flush inside DRAIN restarts the drain window
    idle(); flush = 1'b1; cyc("fl2_first", 1'b0, 1'b0);
    idle(); cyc("fl2_drain1", 1'b0, 1'b0);
    idle(); flush = 1'b1; cyc("fl2_restart", 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) cyc("fl2_drain", 1'b0, 1'b0);
    cyc("fl2_run", 1'b1, 1'b0);

    // writeback bypass on R7
    drv(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0); cyc("byp_issue_r7", 1'b1, 1'b1);
    drv(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    cyc("byp_wb_cycle", 1'b1, 1'b1);
`else
    cyc("byp_wb_cycle", 1'b0, 1'b0);
`endif
    drv(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0); cyc("byp_next_cycle", 1'b1, 1'b1);
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("byp/stall_count", 32'(stall_count), 32'd5);
`else
    chk("byp/stall_count", 32'(stall_count), 32'd6);
`endif
    idle(); cyc("final_idle", 1'b1, 1'b0);
    chk("final/underflow", 32'(underflow_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
